instr_decode_stage: RTL
=======================

// Module: instr_decode_stage
// PURPOSE
//  RV32I decode stage between fetch and execute. Splits the instruction and drives the
//  register file's two read addresses (register file read is combinational). Muxes the
//  writeback bypass into the operands and builds the immediate. A 32-bit scoreboard
//  stalls on RAW/WAW hazards. Results go to execute through one valid/ready output register.
// PARAMETERS
//  XLEN       32  data/PC width
//  AW          5  register address width (32 registers, x0 hardwired zero)
//  USE_BYPASS  1  1: forward writeback data to operands in the same cycle; 0: no forwarding
// PORTS
//  clk             in   1     clock, all state on rising edge
//  rst             in   1     synchronous reset, active-high
//  instr_in        in   XLEN  instruction from fetch
//  pc_in           in   XLEN  PC of instr_in
//  instrValid_in   in   1     fetch offers instr_in/pc_in
//  instrReady_out  out  1     decode accepts this cycle
//  regOut1Addr_out out  AW    rs1 address to register file
//  regOut2Addr_out out  AW    rs2 address to register file
//  regOut1_in      in   XLEN  register file rs1 data (combinational)
//  regOut2_in      in   XLEN  register file rs2 data (combinational)
//  wbAddr_in       in   AW    writeback address (same signals that drive the register file write port)
//  wbWE_in         in   1     writeback write enable
//  wbData_in       in   XLEN  writeback data
//  flush_in        in   1     discard held output (branch redirect)
//  exValid_out     out  1     output register holds a decoded instruction
//  exReady_in      in   1     execute consumes this cycle
//  exPc_out        out  XLEN  PC
//  exRs1_out       out  XLEN  rs1 operand
//  exRs2_out       out  XLEN  rs2 operand
//  exImm_out       out  XLEN  sign-extended immediate
//  exRd_out        out  AW    destination; 0 if no write
//  exOpcode_out    out  7     opcode[6:0]
//  exFunct3_out    out  3     funct3
//  exFunct7b5_out  out  1     instr[30]
//  exIllegal_out   out  1     unknown opcode
// BEHAVIOUR
//  - Reset: exValid_out=0; all ex*_out data=0; scoreboard=0.
//  - regOut1Addr_out=instr_in[19:15] and regOut2Addr_out=instr_in[24:20], always, combinational.
//  - Operand x0: value is 0. Otherwise, if USE_BYPASS && wbWE_in && wbAddr_in==rs, use wbData_in;
//    else use regOut*_in.
//  - Uses: rs1 used by all opcodes except LUI/AUIPC/JAL. rs2 used by BRANCH/STORE/OP.
//    rd written by LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP.
//  - Imm: I={20{i31},i[31:20]}; S={i[31:25],i[11:7]}; B={i31,i7,i[30:25],i[11:8],0};
//    U={i[31:12],12'b0}; J={i31,i[19:12],i20,i[30:21],0}. All sign-extended to XLEN. R-type: 0.
//  - Illegal opcode: exIllegal_out=1, exRd_out=0, no scoreboard set. The instruction is still passed on.
//  - hazard = (used rs!=0 && busy[rs] && !(wbWE_in && wbAddr_in==rs))
//    | (rd!=0 && busy[rd] && !(wbWE_in && wbAddr_in==rd)).
//  - instrReady_out = (!exValid_out || exReady_in) && !hazard && !flush_in.
//    Depends combinationally on instr_in.
//  - accept = instrValid_in && instrReady_out. On accept, the output register loads next cycle:
//    latency 1, throughput 1/cycle.
//  - Without accept: exReady_in && exValid_out clears exValid_out. Otherwise outputs hold stable.
//  - Scoreboard each edge: clear busy[wbAddr_in] if wbWE_in && wbAddr_in!=0, then set busy[rd]
//    on accept with rd!=0. Set wins on the same index. busy[0] is never set.
//  - flush_in: exValid_out<=0 and the held instruction's busy[exRd_out] is cleared.
//    Accept is blocked that cycle. The wb clear still applies.
//  - rst mid-operation: discard held instruction; scoreboard fully cleared.
// TESTING
//  - rst=1 two cycles -> exValid_out=0, instrReady_out=1 with exReady_in=1, all ex*_out=0.
//  - ADDI x1,x0,-5 (0xFFB00093), pc=0x10 -> next cycle exImm_out=0xFFFFFFFB, exRs1_out=0,
//    exRd_out=1; busy[1] set.
//  - ADD x3,x1,x2 right after, x1 busy -> instrReady_out=0. Then wbWE_in=1, wbAddr_in=1,
//    wbData_in=0xCCCCAAAA -> same-cycle accept, exRs1_out=0xCCCCAAAA.
//  - exReady_in=0 for 3 cycles with valid output -> ex*_out unchanged, instrReady_out=0.
//    Release -> next instruction loaded.
//  - SW x2,8(x5) / BEQ / LUI 0xCCCCF / JAL -> imm 8 / branch offset / 0xCCCCF000 / jump offset;
//    exRd_out=0 for SW and BEQ.
//  - Opcode 0x7F -> exIllegal_out=1, no busy set. Flush with held ADDI x4 -> exValid_out=0, busy[4]=0.

Source files
------------

// File: rtl/instr_decode_stage.sv
// RV32I decode stage: splits the fetched instruction, selects bypassed operands, builds the
// immediate, tracks in-flight destinations in a busy scoreboard and hands off through one register.
module instr_decode_stage #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int USE_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            instrValid_in,
    output logic            instrReady_out,
    output logic [AW-1:0]   regOut1Addr_out,
    output logic [AW-1:0]   regOut2Addr_out,
    input  logic [XLEN-1:0] regOut1_in,
    input  logic [XLEN-1:0] regOut2_in,
    input  logic [AW-1:0]   wbAddr_in,
    input  logic            wbWE_in,
    input  logic [XLEN-1:0] wbData_in,
    input  logic            flush_in,
    output logic            exValid_out,
    input  logic            exReady_in,
    output logic [XLEN-1:0] exPc_out,
    output logic [XLEN-1:0] exRs1_out,
    output logic [XLEN-1:0] exRs2_out,
    output logic [XLEN-1:0] exImm_out,
    output logic [AW-1:0]   exRd_out,
    output logic [6:0]      exOpcode_out,
    output logic [2:0]      exFunct3_out,
    output logic            exFunct7b5_out,
    output logic            exIllegal_out
);

    localparam int NREG = 1 << AW;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [6:0]      opcode;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd_field;
    logic [AW-1:0]   rd;
    logic            legal;
    logic            rs1_used;
    logic            rs2_used;
    logic            writes_rd;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            wb_hit_rs1;
    logic            wb_hit_rs2;
    logic            wb_hit_rd;
    logic            hazard;
    logic            accept;

    assign opcode          = instr_in[6:0];
    assign rs1             = instr_in[15 +: AW];
    assign rs2             = instr_in[20 +: AW];
    assign rd_field        = instr_in[7 +: AW];
    assign regOut1Addr_out = rs1;
    assign regOut2Addr_out = rs2;

    always_comb begin
        legal     = 1'b1;
        rs1_used  = 1'b1;
        rs2_used  = 1'b0;
        writes_rd = 1'b0;
        imm32     = 32'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                rs1_used  = 1'b0;
                writes_rd = 1'b1;
                imm32     = {instr_in[31:12], 12'b0};
            end
            OPC_JAL: begin
                rs1_used  = 1'b0;
                writes_rd = 1'b1;
                imm32     = {{12{instr_in[31]}}, instr_in[19:12], instr_in[20],
                             instr_in[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                writes_rd = 1'b1;
                imm32     = {{20{instr_in[31]}}, instr_in[31:20]};
            end
            OPC_BRANCH: begin
                rs2_used = 1'b1;
                imm32    = {{20{instr_in[31]}}, instr_in[7], instr_in[30:25],
                            instr_in[11:8], 1'b0};
            end
            OPC_STORE: begin
                rs2_used = 1'b1;
                imm32    = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            end
            OPC_OP: begin
                rs2_used  = 1'b1;
                writes_rd = 1'b1;
            end
            // FENCE and SYSTEM are legal but never write a tracked destination here
            OPC_FENCE, OPC_SYSTEM: begin
                imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    assign rd  = (legal && writes_rd) ? rd_field : '0;
    assign imm = XLEN'(signed'(imm32));

    always_comb begin
        op1 = regOut1_in;
        op2 = regOut2_in;
        if (rs1 == '0) begin
            op1 = '0;
        end else if ((USE_BYPASS != 0) && wbWE_in && (wbAddr_in == rs1)) begin
            op1 = wbData_in;
        end
        if (rs2 == '0) begin
            op2 = '0;
        end else if ((USE_BYPASS != 0) && wbWE_in && (wbAddr_in == rs2)) begin
            op2 = wbData_in;
        end
    end

    // A writeback landing this cycle releases its register in time for the reader
    assign wb_hit_rs1 = wbWE_in && (wbAddr_in == rs1);
    assign wb_hit_rs2 = wbWE_in && (wbAddr_in == rs2);
    assign wb_hit_rd  = wbWE_in && (wbAddr_in == rd);

    assign hazard = (rs1_used && (rs1 != '0) && busy[rs1] && !wb_hit_rs1)
                  || (rs2_used && (rs2 != '0) && busy[rs2] && !wb_hit_rs2)
                  || ((rd != '0) && busy[rd] && !wb_hit_rd);

    assign instrReady_out = (!exValid_out || exReady_in) && !hazard && !flush_in;
    assign accept         = instrValid_in && instrReady_out;

    // Clears first, then the new destination, so a set on the same index wins
    always_comb begin
        busy_next = busy;
        if (wbWE_in && (wbAddr_in != '0)) begin
            busy_next[wbAddr_in] = 1'b0;
        end
        if (flush_in && exValid_out && (exRd_out != '0)) begin
            busy_next[exRd_out] = 1'b0;
        end
        if (accept && (rd != '0)) begin
            busy_next[rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exValid_out    <= 1'b0;
            exPc_out       <= '0;
            exRs1_out      <= '0;
            exRs2_out      <= '0;
            exImm_out      <= '0;
            exRd_out       <= '0;
            exOpcode_out   <= '0;
            exFunct3_out   <= '0;
            exFunct7b5_out <= 1'b0;
            exIllegal_out  <= 1'b0;
        end else if (flush_in) begin
            exValid_out <= 1'b0;
        end else if (accept) begin
            exValid_out    <= 1'b1;
            exPc_out       <= pc_in;
            exRs1_out      <= op1;
            exRs2_out      <= op2;
            exImm_out      <= imm;
            exRd_out       <= rd;
            exOpcode_out   <= opcode;
            exFunct3_out   <= instr_in[14:12];
            exFunct7b5_out <= instr_in[30];
            exIllegal_out  <= !legal;
        end else if (exReady_in && exValid_out) begin
            exValid_out <= 1'b0;
        end
    end

endmodule
